// File: rtl/w_flush_sched.sv
// Write-data flush scheduler: steers tagged W beats into per-burst FIFOs,
// flushes each FIFO on its last beat and grants drains round-robin.
module w_flush_sched #(
  parameter int NUM_FIFO = 4,
  parameter int LEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [10:0]         aw_id,
  input  logic [LEN_W-1:0]    aw_len,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [10:0]         w_id,
  input  logic [NUM_FIFO-1:0] fifo_ready,
  input  logic [NUM_FIFO-1:0] fifo_flush_done,
  output logic [NUM_FIFO-1:0] fifo_push,
  output logic [NUM_FIFO-1:0] fifo_flush,
  output logic [NUM_FIFO-1:0] fifo_stall,
  output logic                busy
);

  localparam int IW = $clog2(NUM_FIFO);
  localparam int CW = LEN_W + 1;
  localparam logic [NUM_FIFO-1:0] ONE = NUM_FIFO'(1);

  typedef enum logic [1:0] {
    S_FREE,
    S_FILL,
    S_DRAIN
  } slot_e;

  slot_e            st_q  [NUM_FIFO];
  slot_e            st_d  [NUM_FIFO];
  logic [10:0]      id_q  [NUM_FIFO];
  logic [10:0]      id_d  [NUM_FIFO];
  logic [CW-1:0]    exp_q [NUM_FIFO];
  logic [CW-1:0]    exp_d [NUM_FIFO];
  logic [CW-1:0]    cnt_q [NUM_FIFO];
  logic [CW-1:0]    cnt_d [NUM_FIFO];

  logic             gnt_v_q, gnt_v_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic             free_any;
  logic [IW-1:0]    free_idx;
  logic             dup;
  logic             w_hit;
  logic [IW-1:0]    w_idx;
  logic             drn_hit;
  logic [IW-1:0]    drn_idx;
  logic             any_busy;
  logic             aw_fire;
  logic             w_fire;
  logic             last;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    dup      = 1'b0;
    w_hit    = 1'b0;
    w_idx    = '0;
    any_busy = 1'b0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (st_q[i] == S_FREE && !free_any) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (st_q[i] == S_FILL && id_q[i] == aw_id) begin
        dup = 1'b1;
      end
      if (st_q[i] == S_FILL && id_q[i] == w_id) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
      if (st_q[i] != S_FREE) begin
        any_busy = 1'b1;
      end
    end
  end

  // Round-robin scan of draining slots starting at the pointer
  always_comb begin
    drn_hit = 1'b0;
    drn_idx = '0;
    for (int k = 0; k < NUM_FIFO; k++) begin
      int j;
      j = (int'(ptr_q) + k) % NUM_FIFO;
      if (!drn_hit && st_q[j] == S_DRAIN) begin
        drn_hit = 1'b1;
        drn_idx = IW'(j);
      end
    end
  end

  always_comb begin
    aw_ready   = rst | (free_any & ~dup);
    w_ready    = ~rst & w_hit & fifo_ready[w_idx];
    aw_fire    = ~rst & aw_valid & aw_ready;
    w_fire     = w_valid & w_ready;
    last       = w_fire &&
                 ((cnt_q[w_idx] + CW'(1)) == exp_q[w_idx]);
    fifo_push  = w_fire ? (ONE << w_idx) : '0;
    fifo_flush = last ? (ONE << w_idx) : '0;
    fifo_stall = (!rst && gnt_v_q) ? ~(ONE << gnt_q) : '1;
    busy       = ~rst & any_busy;
  end

  always_comb begin
    for (int i = 0; i < NUM_FIFO; i++) begin
      st_d[i]  = st_q[i];
      id_d[i]  = id_q[i];
      exp_d[i] = exp_q[i];
      cnt_d[i] = cnt_q[i];
    end
    gnt_v_d = gnt_v_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;

    if (gnt_v_q) begin
      if (fifo_flush_done[gnt_q]) begin
        st_d[gnt_q]  = S_FREE;
        cnt_d[gnt_q] = '0;
        gnt_v_d      = 1'b0;
        ptr_d        = (gnt_q == IW'(NUM_FIFO - 1)) ? '0 : gnt_q + IW'(1);
      end
    end else if (drn_hit) begin
      gnt_v_d = 1'b1;
      gnt_d   = drn_idx;
    end

    if (w_fire) begin
      cnt_d[w_idx] = cnt_q[w_idx] + CW'(1);
      if (last) begin
        st_d[w_idx] = S_DRAIN;
      end
    end

    if (aw_fire) begin
      st_d[free_idx]  = S_FILL;
      id_d[free_idx]  = aw_id;
      exp_d[free_idx] = CW'(aw_len) + CW'(1);
      cnt_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FIFO; i++) begin
        st_q[i]  <= S_FREE;
        id_q[i]  <= '0;
        exp_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      gnt_v_q <= 1'b0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_FIFO; i++) begin
        st_q[i]  <= st_d[i];
        id_q[i]  <= id_d[i];
        exp_q[i] <= exp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      gnt_v_q <= gnt_v_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_w_flush_sched.sv
// Randomized scoreboard bench for w_flush_sched against a slot-level
// reference model; expectations queued by the driver, checked by a monitor.
module tb_w_flush_sched;

  localparam int N  = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          aw_valid;
  logic          aw_ready;
  logic [10:0]   aw_id;
  logic [LW-1:0] aw_len;
  logic          w_valid;
  logic          w_ready;
  logic [10:0]   w_id;
  logic [N-1:0]  fifo_ready;
  logic [N-1:0]  fifo_flush_done;
  logic [N-1:0]  fifo_push;
  logic [N-1:0]  fifo_flush;
  logic [N-1:0]  fifo_stall;
  logic          busy;

  always #5 clk = ~clk;

  w_flush_sched #(.NUM_FIFO(N), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .aw_id(aw_id), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_id(w_id),
    .fifo_ready(fifo_ready), .fifo_flush_done(fifo_flush_done),
    .fifo_push(fifo_push), .fifo_flush(fifo_flush),
    .fifo_stall(fifo_stall), .busy(busy)
  );

  typedef struct {
    logic         awr;
    logic         wr;
    logic [N-1:0] push;
    logic [N-1:0] flush;
    logic [N-1:0] stall;
    logic         busy;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_grant_free = 0;

  // Reference: 0=free 1=filling 2=draining
  int m_st[N];
  int m_id[N];
  int m_need[N];
  int m_got[N];
  bit m_gv;
  int m_g;
  int m_ptr;

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_st[k] = 0; m_id[k] = 0; m_need[k] = 0; m_got[k] = 0;
    end
    m_gv = 0; m_g = 0; m_ptr = 0;
  endtask

  task automatic model_step(output exp_t e);
    int  fr, wk;
    bit  dup, lst, any, found;
    fr = -1; wk = -1; dup = 0; lst = 0; any = 0;
    for (int k = 0; k < N; k++) begin
      if (m_st[k] == 0 && fr < 0) fr = k;
      if (m_st[k] == 1 && m_id[k] == int'(aw_id)) dup = 1;
      if (m_st[k] == 1 && m_id[k] == int'(w_id)) wk = k;
      if (m_st[k] != 0) any = 1;
    end
    e.awr   = rst ? 1'b1 : (fr >= 0 && !dup);
    e.wr    = !rst && wk >= 0 && fifo_ready[wk];
    e.push  = '0;
    e.flush = '0;
    if (w_valid && e.wr) begin
      e.push[wk] = 1'b1;
      if (m_got[wk] + 1 == m_need[wk]) begin
        lst = 1;
        e.flush[wk] = 1'b1;
      end
    end
    e.stall = '1;
    if (!rst && m_gv) e.stall[m_g] = 1'b0;
    e.busy = !rst && any;

    if (rst) begin
      model_reset();
      return;
    end
    if (m_gv) begin
      if (fifo_flush_done[m_g]) begin
        m_st[m_g] = 0; m_got[m_g] = 0; m_gv = 0;
        m_ptr = (m_g + 1) % N;
        n_grant_free++;
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && m_st[j] == 2) begin
          found = 1; m_gv = 1; m_g = j;
        end
      end
    end
    if (e.push != '0) begin
      n_push++;
      m_got[wk]++;
      if (lst) m_st[wk] = 2;
    end
    if (aw_valid && e.awr) begin
      m_st[fr] = 1; m_id[fr] = int'(aw_id);
      m_need[fr] = int'(aw_len) + 1; m_got[fr] = 0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("aw_ready",   {7'd0, aw_ready},   {7'd0, e.awr});
        chk("w_ready",    {7'd0, w_ready},    {7'd0, e.wr});
        chk("fifo_push",  8'(fifo_push),      8'(e.push));
        chk("fifo_flush", 8'(fifo_flush),     8'(e.flush));
        chk("fifo_stall", 8'(fifo_stall),     8'(e.stall));
        chk("busy",       {7'd0, busy},       {7'd0, e.busy});
      end
    end
  end

  initial begin : driver
    exp_t e;
    int   fills[$];
    rst = 1'b1; aw_valid = 1'b0; aw_id = '0; aw_len = '0;
    w_valid = 1'b0; w_id = '0; fifo_ready = '0; fifo_flush_done = '0;
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst      = (i < 3) || ($urandom_range(0, 399) == 0);
      aw_valid = ($urandom_range(0, 9) < 4);
      aw_id    = 11'($urandom_range(0, 7));
      aw_len   = ($urandom_range(0, 19) == 0) ? LW'(7)
                 : LW'($urandom_range(0, 3));
      w_valid  = ($urandom_range(0, 9) < 7);
      fills.delete();
      for (int k = 0; k < N; k++)
        if (m_st[k] == 1) fills.push_back(m_id[k]);
      if (fills.size() > 0 && $urandom_range(0, 9) < 8)
        w_id = 11'(fills[$urandom_range(0, fills.size() - 1)]);
      else
        w_id = 11'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        fifo_ready[k]      = ($urandom_range(0, 3) != 0);
        fifo_flush_done[k] = ($urandom_range(0, 3) == 0);
      end
      #2;
      model_step(e);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    repeat (3) @(posedge clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sbq_drain got %0d want 0", sbq.size());
    end
    n_chk++;
    if (n_push == 0 || n_grant_free == 0) begin
      n_fail++;
      $display("FAIL activity got %0d pushes %0d frees want nonzero",
               n_push, n_grant_free);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
